// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state codes, parity selectors and the
// default frame data width used by both the transmitter and the RX deserializer.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    // Transmit FSM state codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity type selectors
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register plus bit counter for the UART transmitter. The FSM loads
// a byte, then shifts once per completed data bit. next_bit is the LSB the
// register will hold after this edge, which lets the parent register TX_OUT
// without an extra cycle of latency. done flags the last data bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic              next_bit,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shreg_reg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [CNT_W-1:0]  bit_cnt_next;

    // Right-shift network: each bit takes its upper neighbour, MSB fills with 0
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == DATA_W - 1) begin : g_msb
                assign shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shifted[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    // Next-state for shift register and bit counter; load takes priority
    always_comb begin
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        if (load) begin
            shreg_next   = data_in;
            bit_cnt_next = '0;
        end else if (shift) begin
            shreg_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    assign next_bit = shreg_next[0];
    assign done     = (bit_cnt_reg == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: accepts a byte on DATA_VALID while idle and sends
// start, DATA_W data bits LSB first, optional parity and stop, each held for
// an effective prescale (minimum 2) clock cycles. TX_OUT and busy are
// registered from the next-state values so they change on the accept edge.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PRE_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VALID,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic [PRE_W-1:0]  prescale,
    output logic              TX_OUT,
    output logic              busy
);

    logic [2:0]       state_reg,    state_next;
    logic [PRE_W-1:0] edge_cnt_reg, edge_cnt_next;
    logic [PRE_W-1:0] pre_reg,      pre_next;
    logic             par_en_reg,   par_en_next;
    logic             par_reg,      par_next;
    logic             tx_out_reg,   tx_out_next;
    logic             busy_reg,     busy_next;

    logic [PRE_W-1:0] last_edge;
    logic             bit_end;
    logic             ser_load;
    logic             ser_shift;
    logic             ser_next_bit;
    logic             ser_done;

    assign last_edge = pre_reg - 1'b1;
    assign bit_end   = (edge_cnt_reg == last_edge);

    uart_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .shift    (ser_shift),
        .data_in  (P_DATA),
        .next_bit (ser_next_bit),
        .done     (ser_done)
    );

    // FSM transitions, frame-setting latches and bit-period counter
    always_comb begin
        state_next    = state_reg;
        pre_next      = pre_reg;
        par_en_next   = par_en_reg;
        par_next      = par_reg;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        edge_cnt_next = (state_reg == ST_IDLE || bit_end) ? '0 : edge_cnt_reg + 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    state_next  = ST_START;
                    ser_load    = 1'b1;
                    pre_next    = (prescale < PRE_W'(2)) ? PRE_W'(2) : prescale;
                    par_en_next = PAR_EN;
                    par_next    = ^P_DATA ^ PAR_TYP;
                end
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (ser_done) state_next = par_en_reg ? ST_PARITY : ST_STOP;
                    else          ser_shift  = 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output mux evaluated on the next state so the registered line has no lag
    always_comb begin
        busy_next = (state_next != ST_IDLE);
        case (state_next)
            ST_START:  tx_out_next = 1'b0;
            ST_DATA:   tx_out_next = ser_next_bit;
            ST_PARITY: tx_out_next = par_reg;
            default:   tx_out_next = 1'b1;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            edge_cnt_reg <= '0;
            pre_reg      <= '0;
            par_en_reg   <= 1'b0;
            par_reg      <= 1'b0;
            tx_out_reg   <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            pre_reg      <= pre_next;
            par_en_reg   <= par_en_next;
            par_reg      <= par_next;
            tx_out_reg   <= tx_out_next;
            busy_reg     <= busy_next;
        end
    end

    assign TX_OUT = tx_out_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: each frame is compared against a line model built
// from the frame rules (start 0, data LSB first, parity from the count of ones,
// stop 1, each bit held for the effective prescale).
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int DATA_W = 8;
    localparam int PRE_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] P_DATA;
    logic              DATA_VALID;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic [PRE_W-1:0]  prescale;
    logic              TX_OUT;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DATA_W (DATA_W),
        .PRE_W  (PRE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_of(input int pre);
        return (pre < 2) ? 2 : pre;
    endfunction

    // Present a request while idle; returns at posedge+1 after the accept edge
    task automatic start_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                               input int pre, input bit hold);
        @(posedge clk);
        #1;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        prescale   = PRE_W'(pre);
        DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) DATA_VALID = 1'b0;
    endtask

    // Check the whole line waveform from the first start cycle through the idle cycle.
    // glitch_at >= 0 raises a one-cycle foreign request with scrambled settings there.
    task automatic check_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                               input int pre, input int glitch_at, input string name);
        int   eff;
        int   bits[$];
        int   ones;
        int   cyc;
        int   ok;
        int   busy_hi;
        logic exp_bit;
        eff  = eff_of(pre);
        ones = $countones(d);
        bits = {};
        bits.push_back(0);
        for (int i = 0; i < 8; i++) bits.push_back((d >> i) & 1);
        if (pen) bits.push_back((ones + (ptyp ? 1 : 0)) % 2);
        bits.push_back(1);
        cyc     = 0;
        busy_hi = 0;
        for (int b = 0; b < bits.size(); b++) begin
            exp_bit = (bits[b] != 0);
            ok = 0;
            for (int k = 0; k < eff; k++) begin
                @(negedge clk);
                if (TX_OUT === exp_bit) ok++;
                if (busy === 1'b1) busy_hi++;
                if (glitch_at >= 0 && cyc == glitch_at) begin
                    DATA_VALID = 1'b1;
                    P_DATA     = 8'h3C;
                    prescale   = PRE_W'($urandom);
                    PAR_EN     = ~PAR_EN;
                    PAR_TYP    = ~PAR_TYP;
                end else if (glitch_at >= 0 && cyc == glitch_at + 1) begin
                    DATA_VALID = 1'b0;
                end
                cyc++;
            end
            check_val($sformatf("%s bit%0d cycles", name, b), ok, eff);
        end
        check_val($sformatf("%s busy cycles", name), busy_hi, bits.size() * eff);
        @(negedge clk);
        check_val($sformatf("%s idle tx", name), TX_OUT, 1);
        check_val($sformatf("%s idle busy", name), busy, 0);
        $display("frame %s data=0x%02h par_en=%0d par_typ=%0d eff_pre=%0d cycles=%0d",
                 name, d, pen, ptyp, eff, bits.size() * eff);
    endtask

    initial begin
        logic [7:0] d;
        bit         pen;
        bit         ptyp;
        int         pre;
        int         g;

        rst        = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = PRE_W'(8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset tx", TX_OUT, 1);
        check_val("reset busy", busy, 0);
        rst        = 1'b0;
        DATA_VALID = 1'b0;
        @(negedge clk);
        check_val("post-reset tx", TX_OUT, 1);
        check_val("post-reset busy", busy, 0);

        // Directed frames
        start_frame(8'hA5, 1'b0, PAR_EVEN, 8, 1'b0);
        check_frame(8'hA5, 1'b0, PAR_EVEN, 8, -1, "a5_nopar");
        start_frame(8'h0F, 1'b1, PAR_EVEN, 16, 1'b0);
        check_frame(8'h0F, 1'b1, PAR_EVEN, 16, -1, "0f_even");
        start_frame(8'h0F, 1'b1, PAR_ODD, 16, 1'b0);
        check_frame(8'h0F, 1'b1, PAR_ODD, 16, -1, "0f_odd");

        // Foreign request mid-frame is ignored, and no second frame follows
        start_frame(8'hA5, 1'b0, PAR_EVEN, 8, 1'b0);
        check_frame(8'hA5, 1'b0, PAR_EVEN, 8, 37, "a5_glitch");
        repeat (4) begin
            @(negedge clk);
            check_val("after glitch tx", TX_OUT, 1);
            check_val("after glitch busy", busy, 0);
        end

        // Minimum prescale clamp
        start_frame(8'h81, 1'b1, PAR_ODD, 0, 1'b0);
        check_frame(8'h81, 1'b1, PAR_ODD, 0, -1, "pre0");
        start_frame(8'h7E, 1'b0, PAR_EVEN, 1, 1'b0);
        check_frame(8'h7E, 1'b0, PAR_EVEN, 1, -1, "pre1");
        start_frame(8'h01, 1'b1, PAR_EVEN, 2, 1'b0);
        check_frame(8'h01, 1'b1, PAR_EVEN, 2, -1, "pre2");

        // Back-to-back with DATA_VALID held: exactly one idle cycle between frames
        start_frame(8'h55, 1'b1, PAR_EVEN, 4, 1'b1);
        P_DATA = 8'hAA;
        check_frame(8'h55, 1'b1, PAR_EVEN, 4, -1, "b2b_55");
        @(posedge clk);
        #1;
        DATA_VALID = 1'b0;
        check_frame(8'hAA, 1'b1, PAR_EVEN, 4, -1, "b2b_aa");

        // Reset during data bit 3 together with a new request: frame dropped, nothing accepted
        start_frame(8'hC3, 1'b0, PAR_EVEN, 4, 1'b0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0)  check_val("rst frame start", TX_OUT, 0);
            if (c == 16) check_val("rst frame bit3", TX_OUT, 0);
        end
        rst        = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA     = 8'h81;
        @(negedge clk);
        check_val("mid-frame rst tx", TX_OUT, 1);
        check_val("mid-frame rst busy", busy, 0);
        rst        = 1'b0;
        DATA_VALID = 1'b0;
        @(negedge clk);
        check_val("rst wins tx", TX_OUT, 1);
        check_val("rst wins busy", busy, 0);
        start_frame(8'h3C, 1'b1, PAR_ODD, 6, 1'b0);
        check_frame(8'h3C, 1'b1, PAR_ODD, 6, -1, "after_rst");

        // Loopback-style run: prescale 8 with parity, random bytes
        for (int n = 0; n < 200; n++) begin
            d    = 8'($urandom);
            ptyp = 1'($urandom);
            start_frame(d, 1'b1, ptyp, 8, 1'b0);
            check_frame(d, 1'b1, ptyp, 8, -1, $sformatf("loop%0d", n));
        end

        // Fully random settings, some with a mid-frame foreign request
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            pre  = $urandom_range(0, 20);
            g    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1;
            start_frame(d, pen, ptyp, pre, 1'b0);
            check_frame(d, pen, ptyp, pre, g, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
